// File: rtl/ntt_bitrev_perm_if.sv
// Coefficient-BRAM port bundle for the bit-reversal permuter: start/busy/done plus BRAM port B.
// Latency: none (wiring only).
// Backpressure: none; the permuter owns the BRAM port while busy and ignores start until idle.
// Ports: start (req), busy/done (status), bram_addr/en/we/din (to BRAM), bram_dout (from BRAM),
//        checksum (only when NTT_PERM_CHECKSUM_EN is defined).
// master = permuter side, slave = PS / BRAM side.
interface ntt_bitrev_perm_if #(
    parameter int LOG_N  = 10,
    parameter int DATA_W = 64
);
    logic              start;
    logic              busy;
    logic              done;
    logic [LOG_N-1:0]  bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
`ifdef NTT_PERM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport master (
        input  start,
        input  bram_dout,
        output busy,
        output done,
        output bram_addr,
        output bram_en,
        output bram_we,
        output bram_din
`ifdef NTT_PERM_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start,
        output bram_dout,
        input  busy,
        input  done,
        input  bram_addr,
        input  bram_en,
        input  bram_we,
        input  bram_din
`ifdef NTT_PERM_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/ntt_bitrev_perm.sv
// In-place bit-reversal permutation of the NTT coefficient BRAM, run between PS load and NTT start.
// Latency: busy for N + S*(4+2*RD_LAT) cycles, S = (N - 2**ceil(LOG_N/2))/2; done pulses as busy falls.
// Backpressure: none; start is sampled only in IDLE, ignored while busy and in the done cycle.
// Ports: clk, rst (async, active-high), bus (ntt_bitrev_perm_if.master): start in; busy, done,
//        bram_addr/en/we/din out; bram_dout in; checksum out with NTT_PERM_CHECKSUM_EN.
// Optional feature macro: NTT_PERM_CHECKSUM_EN (XOR of every word read during the permutation).
module ntt_bitrev_perm #(
    parameter int LOG_N  = 10,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    ntt_bitrev_perm_if.master  bus
);
    localparam int N      = 1 << LOG_N;
    localparam int IW     = LOG_N + 1;
    localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [IW-1:0]     I_LAST    = IW'(N - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_RD_A,
        S_WT_A,
        S_RD_B,
        S_WT_B,
        S_WR_A,
        S_WR_B,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   reg_a_q, reg_a_d;
    logic [DATA_W-1:0]   reg_b_q, reg_b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                en_q, en_d;
    logic                we_q, we_d;
    logic [LOG_N-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;

    logic [LOG_N-1:0]    j;
    logic                swap;
    logic                cap_a;
    logic                cap_b;
    logic                accept;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
        logic [LOG_N-1:0] r;
        for (int b = 0; b < LOG_N; b++) begin
            r[b] = v[LOG_N-1-b];
        end
        return r;
    endfunction

    // i only changes on the way back to SCAN, so j stays valid through the whole swap.
    assign j      = bitrev(i_q[LOG_N-1:0]);
    // Swap only from the lower index of a pair; palindromes (j == i) are never touched.
    assign swap   = {1'b0, j} > i_q;
    // Read data is valid on the last wait cycle, RD_LAT cycles after the read was issued.
    assign cap_a  = (state_q == S_WT_A) && (wcnt_q == WCNT_LAST);
    assign cap_b  = (state_q == S_WT_B) && (wcnt_q == WCNT_LAST);
    assign accept = (state_q == S_IDLE) && bus.start;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        wcnt_d  = wcnt_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SCAN;
                    i_d     = '0;
                end
            end
            S_SCAN: begin
                if (swap) begin
                    state_d = S_RD_A;
                end else if (i_q == I_LAST) begin
                    state_d = S_FIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_RD_A: begin
                state_d = S_WT_A;
                wcnt_d  = '0;
            end
            S_WT_A: begin
                if (cap_a) begin
                    reg_a_d = bus.bram_dout;
                    state_d = S_RD_B;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RD_B: begin
                state_d = S_WT_B;
                wcnt_d  = '0;
            end
            S_WT_B: begin
                if (cap_b) begin
                    reg_b_d = bus.bram_dout;
                    state_d = S_WR_A;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WR_A: begin
                state_d = S_WR_B;
            end
            S_WR_B: begin
                if (i_q == I_LAST) begin
                    state_d = S_FIN;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered: decode them from the next state so they line up with it.
    always_comb begin
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
        en_d   = (state_d == S_RD_A) || (state_d == S_RD_B) ||
                 (state_d == S_WR_A) || (state_d == S_WR_B);
        we_d   = (state_d == S_WR_A) || (state_d == S_WR_B);
        addr_d = addr_q;
        din_d  = din_q;

        case (state_d)
            S_RD_A: addr_d = i_q[LOG_N-1:0];
            S_RD_B: addr_d = j;
            S_WR_A: begin
                addr_d = i_q[LOG_N-1:0];
                din_d  = reg_b_d;
            end
            S_WR_B: begin
                addr_d = j;
                din_d  = reg_a_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            wcnt_q  <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            wcnt_q  <= wcnt_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bram_en   = en_q;
    assign bus.bram_we   = we_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;

`ifdef NTT_PERM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Every captured word is folded in exactly once; the value then holds until the next start.
    always_comb begin
        checksum_d = checksum_q;
        if (accept) begin
            checksum_d = '0;
        end else if (cap_a || cap_b) begin
            checksum_d = checksum_q ^ bus.bram_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule
